// File: rtl/taxi_eth_mac_addr_swap.sv
// Swaps the Ethernet DST/SRC MAC fields of each 64-bit AXI-stream frame (one hold + one output register).
// Optional TAXI_MAC_SWAP_CFG_EN adds cfg_swap_enable, sampled at beat 0, to bypass the swap per frame.
module taxi_eth_mac_addr_swap #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8,
  parameter int ID_W   = 8,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TAXI_MAC_SWAP_CFG_EN
  input  logic              cfg_swap_enable,
`endif
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic [ID_W-1:0]   s_axis_tid,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [ID_W-1:0]   m_axis_tid,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              stat_swap,
  output logic              stat_short
);

  if ((DATA_W != 32'd64) || (KEEP_W != 32'd8)) begin : g_param_check
    $fatal(1, "taxi_eth_mac_addr_swap supports only DATA_W=64, KEEP_W=8");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_BODY = 2'd2} state_t;

  // Frame bytes 0-15: beat 0 holds DST[0:5] + SRC[0:1], beat 1 holds SRC[2:5] in its low half.
  function automatic logic [63:0] swap_beat0(input logic [63:0] b0, input logic [63:0] b1);
    return {b0[15:0], b1[31:0], b0[63:48]};
  endfunction

  function automatic logic [63:0] swap_beat1(input logic [63:0] b0, input logic [63:0] b1);
    return {b1[63:32], b0[47:16]};
  endfunction

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   h_data_r, h_data_s, o_data_r, o_data_s;
  logic [KEEP_W-1:0]   h_keep_r, h_keep_s, o_keep_r, o_keep_s;
  logic                h_last_r, h_last_s, o_last_r, o_last_s;
  logic [ID_W-1:0]     h_id_r, h_id_s, o_id_r, o_id_s;
  logic [USER_W-1:0]   h_user_r, h_user_s, o_user_r, o_user_s;
  logic                h_valid_r, h_valid_s, o_valid_r, o_valid_s;
  logic                h_short_r, h_short_s;
  logic                stat_swap_r, stat_short_r, swap_pulse_s, short_pulse_s;
  logic                advance_ok_s, accept_s, is_short_s, do_swap_s, swap_en_s;

`ifdef TAXI_MAC_SWAP_CFG_EN
  logic                cfg_r, cfg_s;
  assign swap_en_s = cfg_r;
`else
  assign swap_en_s = 1'b1;
`endif

  assign advance_ok_s  = !o_valid_r || m_axis_tready;
  assign s_axis_tready = advance_ok_s && !rst;
  assign accept_s      = s_axis_tvalid && s_axis_tready;
  // A last beat 1 without all of bytes 8-11 means the frame is under 12 bytes.
  assign is_short_s    = s_axis_tlast && (s_axis_tkeep[3:0] != 4'hF);
  assign do_swap_s     = swap_en_s && !is_short_s;

  // Frame-position state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: beat 0 opens HDR, beat 1 opens BODY, any tlast returns to IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s && !s_axis_tlast) state_s = ST_HDR;  else state_s = ST_IDLE;
      ST_HDR:  if (accept_s) state_s = s_axis_tlast ? ST_IDLE : ST_BODY; else state_s = ST_HDR;
      ST_BODY: if (accept_s && s_axis_tlast) state_s = ST_IDLE; else state_s = ST_BODY;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath next values for hold (H) and output (O) registers
  always_comb begin
    o_data_s = o_data_r; o_keep_s = o_keep_r; o_last_s = o_last_r;
    o_id_s = o_id_r; o_user_s = o_user_r; o_valid_s = o_valid_r;
    h_data_s = h_data_r; h_keep_s = h_keep_r; h_last_s = h_last_r;
    h_id_s = h_id_r; h_user_s = h_user_r; h_valid_s = h_valid_r; h_short_s = h_short_r;
`ifdef TAXI_MAC_SWAP_CFG_EN
    cfg_s = cfg_r;
`endif
    swap_pulse_s = 1'b0;
    short_pulse_s = 1'b0;
    if (advance_ok_s) begin
      o_valid_s = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (h_valid_r) begin
            o_data_s = h_data_r; o_keep_s = h_keep_r; o_last_s = h_last_r;
            o_id_s = h_id_r; o_user_s = h_user_r; o_valid_s = 1'b1;
            short_pulse_s = h_short_r;
            h_valid_s = 1'b0;
          end else begin
            h_valid_s = 1'b0;
          end
          if (accept_s) begin
            h_data_s = s_axis_tdata; h_keep_s = s_axis_tkeep; h_last_s = s_axis_tlast;
            h_id_s = s_axis_tid; h_user_s = s_axis_tuser; h_valid_s = 1'b1;
            h_short_s = s_axis_tlast;
`ifdef TAXI_MAC_SWAP_CFG_EN
            cfg_s = cfg_swap_enable;
`endif
          end else begin
            h_short_s = h_short_r;
          end
        end
        ST_HDR: begin
          if (accept_s) begin
            o_data_s = h_data_r; o_keep_s = h_keep_r; o_last_s = h_last_r;
            o_id_s = h_id_r; o_user_s = h_user_r; o_valid_s = 1'b1;
            h_data_s = s_axis_tdata; h_keep_s = s_axis_tkeep; h_last_s = s_axis_tlast;
            h_id_s = s_axis_tid; h_user_s = s_axis_tuser; h_valid_s = 1'b1;
            h_short_s = 1'b0;
            if (do_swap_s) begin
              o_data_s = swap_beat0(h_data_r, s_axis_tdata);
              h_data_s = swap_beat1(h_data_r, s_axis_tdata);
              swap_pulse_s = 1'b1;
            end else begin
              short_pulse_s = is_short_s;
            end
          end else begin
            o_valid_s = 1'b0;
          end
        end
        ST_BODY: begin
          if (accept_s) begin
            o_data_s = h_data_r; o_keep_s = h_keep_r; o_last_s = h_last_r;
            o_id_s = h_id_r; o_user_s = h_user_r; o_valid_s = 1'b1;
            h_data_s = s_axis_tdata; h_keep_s = s_axis_tkeep; h_last_s = s_axis_tlast;
            h_id_s = s_axis_tid; h_user_s = s_axis_tuser; h_valid_s = 1'b1;
            h_short_s = 1'b0;
          end else begin
            o_valid_s = 1'b0;
          end
        end
        default: begin
          o_valid_s = 1'b0;
          h_valid_s = 1'b0;
        end
      endcase
    end else begin
      o_valid_s = o_valid_r;
    end
  end

  // Valid flags, status pulses and frame config with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_r    <= 1'b0;
      h_valid_r    <= 1'b0;
      h_short_r    <= 1'b0;
      stat_swap_r  <= 1'b0;
      stat_short_r <= 1'b0;
`ifdef TAXI_MAC_SWAP_CFG_EN
      cfg_r        <= 1'b1;
`endif
    end else begin
      o_valid_r    <= o_valid_s;
      h_valid_r    <= h_valid_s;
      h_short_r    <= h_short_s;
      stat_swap_r  <= swap_pulse_s;
      stat_short_r <= short_pulse_s;
`ifdef TAXI_MAC_SWAP_CFG_EN
      cfg_r        <= cfg_s;
`endif
    end
  end

  // Payload registers; meaningful only while the matching valid flag is set
  always_ff @(posedge clk) begin
    o_data_r <= o_data_s; o_keep_r <= o_keep_s; o_last_r <= o_last_s;
    o_id_r   <= o_id_s;   o_user_r <= o_user_s;
    h_data_r <= h_data_s; h_keep_r <= h_keep_s; h_last_r <= h_last_s;
    h_id_r   <= h_id_s;   h_user_r <= h_user_s;
  end

  assign m_axis_tdata  = o_data_r;
  assign m_axis_tkeep  = o_keep_r;
  assign m_axis_tlast  = o_last_r;
  assign m_axis_tid    = o_id_r;
  assign m_axis_tuser  = o_user_r;
  assign m_axis_tvalid = o_valid_r;
  assign stat_swap     = stat_swap_r;
  assign stat_short    = stat_short_r;

endmodule

// File: tb/tb_taxi_eth_mac_addr_swap.sv
// Self-checking bench for taxi_eth_mac_addr_swap: byte-level reference swap model and output scoreboard.
module tb_taxi_eth_mac_addr_swap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tid;
  logic [0:0]  s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [0:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        stat_swap;
  logic        stat_short;
`ifdef TAXI_MAC_SWAP_CFG_EN
  logic        cfg_swap_enable;
`endif

  taxi_eth_mac_addr_swap dut (
    .clk(clk), .rst(rst),
`ifdef TAXI_MAC_SWAP_CFG_EN
    .cfg_swap_enable(cfg_swap_enable),
`endif
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tid(s_axis_tid), .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .stat_swap(stat_swap), .stat_short(stat_short)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic        user;
  } beat_t;

  beat_t      obs[$];
  beat_t      exp_q[$];
  int         out_cyc[$];
  int         in_cyc[$];
  int         cyc = 0;
  int         swap_cnt = 0;
  int         short_cnt = 0;
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         total_cnt = 0;
  int         rdy_pct = 100;
  int         cfg_toggle_beat = -1;
  logic [7:0] fr_bytes[$];
  logic [7:0] fr_id[$];
  logic       fr_user[$];

  function automatic beat_t mask_beat(input beat_t b);
    beat_t r;
    r = b;
    for (int i = 0; i < 8; i++) if (!r.keep[i]) r.data[8*i +: 8] = 8'h00;
    return r;
  endfunction

  // Cycle counter used for latency and contiguity measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: records handshakes on both sides and status pulses
  always @(negedge clk) begin
    beat_t t;
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      t.data = m_axis_tdata; t.keep = m_axis_tkeep; t.last = m_axis_tlast;
      t.id = m_axis_tid; t.user = m_axis_tuser[0];
      obs.push_back(mask_beat(t));
      out_cyc.push_back(cyc);
    end
    if (!rst && s_axis_tvalid && s_axis_tready) in_cyc.push_back(cyc);
    if (!rst && stat_swap)  swap_cnt  <= swap_cnt + 1;
    if (!rst && stat_short) short_cnt <= short_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs_v, input logic [127:0] exp_v);
    total_cnt++;
    assert (obs_v === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
  endtask

  task automatic make_frame(input int len);
    fr_bytes.delete(); fr_id.delete(); fr_user.delete();
    for (int i = 0; i < len; i++) fr_bytes.push_back(8'($urandom));
    for (int b = 0; b < (len + 7) / 8; b++) begin
      fr_id.push_back(8'($urandom));
      fr_user.push_back(1'($urandom));
    end
  endtask

  task automatic set_addr(input logic [47:0] dst, input logic [47:0] src);
    for (int i = 0; i < 6; i++) begin
      fr_bytes[i]     = dst[47 - 8*i -: 8];
      fr_bytes[6 + i] = src[47 - 8*i -: 8];
    end
  endtask

  // Reference: exchange byte ranges 0-5 and 6-11 of frames of 12+ bytes, then slice into beats
  task automatic model_frame(input bit en);
    logic [7:0] ob[$];
    logic [7:0] t;
    beat_t      e;
    int         nb;
    ob = fr_bytes;
    if (en && ob.size() >= 12) begin
      for (int i = 0; i < 6; i++) begin
        t = ob[i]; ob[i] = ob[i + 6]; ob[i + 6] = t;
      end
    end
    nb = (ob.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int i = 0; i < 8; i++) begin
        if (8*b + i < ob.size()) begin
          e.data[8*i +: 8] = ob[8*b + i];
          e.keep[i] = 1'b1;
        end
      end
      e.last = (b == nb - 1);
      e.id = fr_id[b];
      e.user = fr_user[b];
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input int valid_pct, input int max_beats);
    int nb;
    bit acc;
    int guard;
    nb = (fr_bytes.size() + 7) / 8;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      while (valid_pct < 100 && int'($urandom_range(99)) >= valid_pct) begin
        s_axis_tvalid = 1'b0;
        tick();
      end
`ifdef TAXI_MAC_SWAP_CFG_EN
      if (b == cfg_toggle_beat) cfg_swap_enable = 1'b1;
`endif
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      for (int i = 0; i < 8; i++) begin
        if (8*b + i < fr_bytes.size()) begin
          s_axis_tdata[8*i +: 8] = fr_bytes[8*b + i];
          s_axis_tkeep[i] = 1'b1;
        end
      end
      s_axis_tlast  = (b == nb - 1);
      s_axis_tid    = fr_id[b];
      s_axis_tuser  = fr_user[b];
      s_axis_tvalid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_axis_tready;
        tick();
        guard++;
        if (!acc && guard >= 2000) begin
          check("s_axis_tready_timeout", 128'(acc), 128'(1));
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_drain(input int ob, input int budget);
    int g;
    g = 0;
    s_axis_tvalid = 1'b0;
    while ((obs.size() - ob) < exp_q.size() && g < budget) begin
      tick();
      g++;
    end
    repeat (4) tick();
  endtask

  task automatic compare_stream(input string tag, input int ob);
    int n;
    int p;
    check({tag, "_count"}, 128'(obs.size() - ob), 128'(exp_q.size()));
    n = (obs.size() - ob < exp_q.size()) ? obs.size() - ob : exp_q.size();
    for (int i = 0; i < n; i++) begin
      p = pass_cnt;
      check(tag, 128'(obs[ob + i]), 128'(exp_q[i]));
      if (pass_cnt == p) break;
    end
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob, ib, sw, sh;
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; s_axis_tuser = '0; s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
`ifdef TAXI_MAC_SWAP_CFG_EN
    cfg_swap_enable = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("reset_s_tready", 128'(s_axis_tready), 128'(0));
    check("reset_stats", 128'({stat_swap, stat_short}), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_s_tready", 128'(s_axis_tready), 128'(1));

    // 64-byte frame with known addresses, sink always ready
    rdy_pct = 100;
    tick();
    ob = obs.size(); ib = in_cyc.size(); sw = swap_cnt; sh = short_cnt;
    make_frame(64);
    set_addr(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02);
    model_frame(1'b1);
    send_frame(100, 1000);
    wait_drain(ob, 200);
    check("t1_have_beats", 128'(obs.size() >= ob + 2 && in_cyc.size() >= ib + 2), 128'(1));
    if (obs.size() >= ob + 2 && in_cyc.size() >= ib + 2) begin
      check("t1_latency", 128'(out_cyc[ob]), 128'(in_cyc[ib + 1] + 1));
      check("t1_out_dst", 128'(obs[ob].data[47:0]), 128'(48'h02_00_00_00_00_02));
      check("t1_out_src_lo", 128'(obs[ob].data[63:48]), 128'(16'h0002));
      check("t1_out_src_hi", 128'(obs[ob + 1].data[31:0]), 128'(32'h0100_0000));
    end
    compare_stream("t1_beat", ob);
    check("t1_stat_swap", 128'(swap_cnt - sw), 128'(1));
    check("t1_stat_short", 128'(short_cnt - sh), 128'(0));

    // Four back-to-back 60-byte frames: output must be contiguous
    ob = obs.size(); sw = swap_cnt;
    for (int f = 0; f < 4; f++) begin
      make_frame(60);
      model_frame(1'b1);
      send_frame(100, 1000);
    end
    wait_drain(ob, 300);
    check("t2_beat_total", 128'(obs.size() - ob), 128'(32));
    if (obs.size() - ob == 32) check("t2_contiguous", 128'(out_cyc[ob + 31] - out_cyc[ob] + 1), 128'(32));
    compare_stream("t2_beat", ob);
    check("t2_stat_swap", 128'(swap_cnt - sw), 128'(4));

    // Short frames of 8, 10, 11 bytes pass unmodified; 12 bytes is the smallest swapped frame
    ob = obs.size(); sw = swap_cnt; sh = short_cnt;
    make_frame(8);  model_frame(1'b1); send_frame(100, 1000);
    make_frame(10); model_frame(1'b1); send_frame(100, 1000);
    make_frame(11); model_frame(1'b1); send_frame(100, 1000);
    make_frame(12); model_frame(1'b1); send_frame(100, 1000);
    wait_drain(ob, 200);
    compare_stream("t3_beat", ob);
    check("t3_stat_short", 128'(short_cnt - sh), 128'(3));
    check("t3_stat_swap", 128'(swap_cnt - sw), 128'(1));

    // Random lengths with random source gaps and sink backpressure
    rdy_pct = 50;
    ob = obs.size(); sw = swap_cnt; sh = short_cnt;
    for (int f = 0; f < 400; f++) begin
      make_frame(($urandom_range(9) == 0) ? int'($urandom_range(1518, 12)) : int'($urandom_range(128, 12)));
      model_frame(1'b1);
      send_frame(70, 100000);
    end
    wait_drain(ob, 5000);
    compare_stream("t4_beat", ob);
    check("t4_stat_swap", 128'(swap_cnt - sw), 128'(400));
    check("t4_stat_short", 128'(short_cnt - sh), 128'(0));

    // Reset after beat 3 of a 64-byte frame, then a fresh frame
    rdy_pct = 100;
    tick();
    make_frame(64);
    send_frame(100, 4);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_tready_in_reset", 128'(s_axis_tready), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_m_tvalid_after_reset", 128'(m_axis_tvalid), 128'(0));
    check("t5_s_tready_after_reset", 128'(s_axis_tready), 128'(1));
    ob = obs.size(); sw = swap_cnt;
    tick();
    make_frame(64);
    set_addr(48'h0A_0B_0C_0D_0E_0F, 48'h12_34_56_78_9A_BC);
    model_frame(1'b1);
    send_frame(100, 1000);
    wait_drain(ob, 200);
    compare_stream("t5_beat", ob);
    check("t5_stat_swap", 128'(swap_cnt - sw), 128'(1));

`ifdef TAXI_MAC_SWAP_CFG_EN
    // Swap disabled at beat 0 and enabled mid-frame: that frame is untouched, the next is swapped
    ob = obs.size(); sw = swap_cnt;
    cfg_swap_enable = 1'b0;
    cfg_toggle_beat = 1;
    make_frame(64); model_frame(1'b0); send_frame(100, 1000);
    cfg_toggle_beat = -1;
    make_frame(64); model_frame(1'b1); send_frame(100, 1000);
    wait_drain(ob, 300);
    compare_stream("t6_beat", ob);
    check("t6_stat_swap", 128'(swap_cnt - sw), 128'(1));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
